// File: rtl/titan_bus_pkg.sv
// -----------------------------------------------------------------------------
// titan_bus_pkg
// Shared definitions for the command-frame path that sits between the SPI byte
// interface and the instruction decoder.
//   - frame geometry (byte count, field widths, byte offsets of each field)
//   - collector state encoding
//   - decoded frame struct and a helper that splits a raw frame into fields
// -----------------------------------------------------------------------------
package titan_bus_pkg;

    localparam int FRAME_BYTES = 8;
    localparam int FRAME_W     = FRAME_BYTES * 8;
    localparam int IDX_W       = 3;

    localparam int INSTR_W = 8;
    localparam int ADDR_W  = 24;
    localparam int VALUE_W = 32;

    // Byte offset of each field within a frame (byte 0 arrives first).
    localparam int INSTR_OFS = 0;
    localparam int ADDR_OFS  = 1;
    localparam int VALUE_OFS = 4;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_COLLECT = 1'b1
    } collect_state_e;

    typedef struct packed {
        logic [INSTR_W-1:0] instruction;
        logic [ADDR_W-1:0]  address;
        logic [VALUE_W-1:0] value;
    } cmd_frame_t;

    // The first received byte ends up in the top byte of the raw frame, so
    // byte k lives at raw[FRAME_W-1-8k -: 8]; multi-byte fields are MSB first.
    function automatic cmd_frame_t unpack_frame(input logic [FRAME_W-1:0] raw);
        cmd_frame_t f;
        f.instruction = raw[FRAME_W-1-8*INSTR_OFS -: INSTR_W];
        f.address     = raw[FRAME_W-1-8*ADDR_OFS  -: ADDR_W];
        f.value       = raw[FRAME_W-1-8*VALUE_OFS -: VALUE_W];
        return f;
    endfunction

endpackage

// File: rtl/frame_timeout_counter.sv
// -----------------------------------------------------------------------------
// frame_timeout_counter
// Counts idle cycles between bytes of a frame and flags expiry.
//   clk_i       system clock
//   rst_n       synchronous active-low reset
//   clr_i       restart the count (a byte was accepted); wins over expiry
//   en_i        count this cycle (collector is mid-frame)
//   expiring_o  combinational: the count reaches TIMEOUT_CYCLES on this edge
//   expired_o   registered one-cycle pulse, the cycle after expiry
// TIMEOUT_CYCLES = 0 disables the counter entirely.
// -----------------------------------------------------------------------------
module frame_timeout_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk_i,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expiring_o,
    output logic expired_o
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST =
        (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic ACTIVE = (TIMEOUT_CYCLES != 0);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             expired_q;

    // The counter holds 0..TIMEOUT_CYCLES-1; the step from LAST is the edge on
    // which the idle count reaches TIMEOUT_CYCLES.
    always_comb begin
        expiring_o = ACTIVE && en_i && !clr_i && (cnt_q == LAST);
    end

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (!en_i || clr_i || expiring_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            expired_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            expired_q <= expiring_o;
        end
    end

    assign expired_o = expired_q;

endmodule

// File: rtl/cmd_frame_assembler.sv
// -----------------------------------------------------------------------------
// cmd_frame_assembler
// Packs the SPI byte stream into 8-byte command frames (opcode, 24-bit address,
// 32-bit value) and hands them to the instruction stage.
//   clk_i, rst_n        clock, synchronous active-low reset
//   spi_ss_i            slave select, active low; high resets the partial frame
//   spi_rx_valid_i      one-cycle strobe for spi_rx_byte_i
//   spi_rx_byte_i       received byte
//   frame_valid_o       holding register contains an unconsumed frame
//   frame_ready_i       consumer accepts the frame
//   instruction_o       frame byte 0
//   address_o           frame bytes 1..3, MSB first
//   value_o             frame bytes 4..7, MSB first
//   byte_index_o        bytes of the in-progress frame received so far
//   timeout_o           one-cycle pulse: partial frame discarded by timeout
//   overflow_o          sticky: a completed frame was dropped
//   overflow_clr_i      clears overflow_o (a same-cycle drop wins)
//
// Handshake: a frame transfers on every rising edge where frame_valid_o and
// frame_ready_i are both high. While frame_valid_o is high and not yet
// accepted, instruction_o/address_o/value_o do not change. A frame completing
// on the same edge as a transfer loads directly, so valid stays high.
// -----------------------------------------------------------------------------
module cmd_frame_assembler
    import titan_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic               clk_i,
    input  logic               rst_n,
    input  logic               spi_ss_i,
    input  logic               spi_rx_valid_i,
    input  logic [7:0]         spi_rx_byte_i,
    output logic               frame_valid_o,
    input  logic               frame_ready_i,
    output logic [INSTR_W-1:0] instruction_o,
    output logic [ADDR_W-1:0]  address_o,
    output logic [VALUE_W-1:0] value_o,
    output logic [IDX_W-1:0]   byte_index_o,
    output logic               timeout_o,
    output logic               overflow_o,
    input  logic               overflow_clr_i
);

    // Only the seven earlier bytes need storing: the eighth is taken straight
    // from the input when the frame completes.
    localparam int SHIFT_W = FRAME_W - 8;

    collect_state_e       state_q, state_d;
    logic [IDX_W-1:0]     index_q, index_d;
    logic [SHIFT_W-1:0]   shift_q;
    cmd_frame_t           frame_q;
    logic                 valid_q, valid_d;
    logic                 overflow_q, overflow_d;

    logic                 byte_accept;
    logic                 last_byte;
    logic                 transfer;
    logic                 load_frame;
    logic                 drop_frame;
    logic                 cnt_en;
    logic                 expiring;
    logic                 expired;
    logic [FRAME_W-1:0]   assembled;

    assign byte_accept = spi_rx_valid_i && !spi_ss_i;
    assign last_byte   = byte_accept && (index_q == IDX_W'(FRAME_BYTES - 1));
    assign transfer    = valid_q && frame_ready_i;
    assign assembled   = {shift_q, spi_rx_byte_i};

    // ---------------- collector FSM: state register ----------------
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- collector FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (byte_accept) begin
                    state_d = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (spi_ss_i || last_byte || expiring) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------- collector FSM: outputs ----------------
    // The idle counter only runs mid-frame; SS high restarts the frame anyway.
    always_comb begin
        cnt_en = 1'b0;
        if (state_q == ST_COLLECT && !spi_ss_i) begin
            cnt_en = 1'b1;
        end
    end

    frame_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i      (clk_i),
        .rst_n      (rst_n),
        .clr_i      (byte_accept),
        .en_i       (cnt_en),
        .expiring_o (expiring),
        .expired_o  (expired)
    );

    // ---------------- byte index ----------------
    always_comb begin
        index_d = index_q;
        if (spi_ss_i || expiring || last_byte) begin
            index_d = '0;
        end else if (byte_accept) begin
            index_d = index_q + 1'b1;
        end
    end

    // ---------------- holding register / overflow ----------------
    assign load_frame = last_byte && (!valid_q || transfer);
    assign drop_frame = last_byte && valid_q && !frame_ready_i;

    always_comb begin
        valid_d = valid_q;
        if (load_frame) begin
            valid_d = 1'b1;
        end else if (transfer) begin
            valid_d = 1'b0;
        end
    end

    always_comb begin
        overflow_d = overflow_q;
        if (drop_frame) begin
            overflow_d = 1'b1;
        end else if (overflow_clr_i) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            index_q    <= '0;
            shift_q    <= '0;
            frame_q    <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            index_q    <= index_d;
            valid_q    <= valid_d;
            overflow_q <= overflow_d;
            if (byte_accept) begin
                shift_q <= {shift_q[SHIFT_W-9:0], spi_rx_byte_i};
            end
            if (load_frame) begin
                frame_q <= unpack_frame(assembled);
            end
        end
    end

    assign frame_valid_o = valid_q;
    assign instruction_o = frame_q.instruction;
    assign address_o     = frame_q.address;
    assign value_o       = frame_q.value;
    assign byte_index_o  = index_q;
    assign timeout_o     = expired;
    assign overflow_o    = overflow_q;

endmodule

// File: doc/cmd_frame_assembler.md
# cmd_frame_assembler

Collects the byte stream produced by the SPI byte interface into fixed 8-byte command frames (opcode, 24-bit address, 32-bit value) and presents each frame to the instruction stage with a valid/ready handshake. It sits directly downstream of `spi_byte_if` and upstream of the instruction decoder. It also absorbs back-pressure with a one-frame holding register, resynchronises on chip-select deassertion or inter-byte timeout, and flags dropped frames.

## Interface
- `TIMEOUT_CYCLES`, default 1024: idle `clk_i` cycles allowed between bytes of one frame; 0 disables the timeout.
- `clk_i`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `spi_ss_i`  in  1  SPI slave select, active low; high means no transaction.
- `spi_rx_valid_i`  in  1  one-cycle pulse: `spi_rx_byte_i` holds a new byte.
- `spi_rx_byte_i`  in  8  received byte.
- `frame_valid_o`  out  1  output frame registers hold an unconsumed frame.
- `frame_ready_i`  in  1  consumer accepts the frame.
- `instruction_o`  out  8  frame byte 0.
- `address_o`  out  24  frame bytes 1–3, MSB first.
- `value_o`  out  32  frame bytes 4–7, MSB first.
- `byte_index_o`  out  3  number of bytes of the in-progress frame received so far.
- `timeout_o`  out  1  one-cycle pulse: a partial frame was discarded by timeout.
- `overflow_o`  out  1  sticky: a completed frame was dropped.
- `overflow_clr_i`  in  1  clears `overflow_o`.

## Operation
- **Collect path**
  - 64-bit shift register plus 3-bit byte index.
  - A byte is accepted when `spi_rx_valid_i` is high and `spi_ss_i` is low; it shifts in from the LSB side and the index increments.
  - Bytes arriving while `spi_ss_i` is high are ignored.
- **Frame completion** (8th byte accepted): the index wraps to 0.
  - If the holding register is free, or is being consumed this cycle (`frame_valid_o && frame_ready_i`): load `instruction_o`/`address_o`/`value_o` from the shift register and set `frame_valid_o`.
  - Otherwise: drop the new frame, set `overflow_o`, and leave the held frame untouched.
- **Handshake**
  - Transfer occurs on an edge where `frame_valid_o && frame_ready_i`.
  - `frame_valid_o` clears after the transfer unless a new frame loads on the same edge.
  - Output data is stable while valid is high and not yet accepted.
- **Collector states**
  - IDLE (index = 0) → COLLECT on an accepted byte.
  - COLLECT → IDLE on the 8th byte, on `spi_ss_i` rising, or on timeout.
  - Collection continues while a frame is held; this is the double-buffering.
- **Timeout counter**
  - Cleared on every accepted byte and counts up in COLLECT.
  - On reaching `TIMEOUT_CYCLES`: index → 0, partial frame discarded, `timeout_o` pulses for one cycle.
  - The counter is inactive in IDLE and when `TIMEOUT_CYCLES` = 0.
- **SS deassert mid-frame:** index → 0 on the next edge, partial frame discarded, no `timeout_o` pulse, no overflow.
- **`overflow_o`:** set by a dropped frame; cleared by `overflow_clr_i`. If set and clear coincide, set wins.

## Timing
- **Reset:** every output is 0; index is 0, counter is 0, state is IDLE. Reset mid-frame discards everything, including a held frame.
- **Latency:** 8th byte accepted at edge N → `frame_valid_o` = 1 and data valid after edge N (visible in cycle N+1).
- **`byte_index_o`:** updates the cycle after each accepted byte.
- **Byte vs. timeout on the same cycle:** the byte wins; the counter clears and no pulse is raised.
- **Byte vs. `spi_ss_i` high on the same cycle:** the byte is ignored and the frame is reset.
- **`timeout_o`:** asserted exactly one cycle, in the cycle after the counter reaches `TIMEOUT_CYCLES`.
- **Throughput:** one frame per 8 accepted bytes, with no bubble when the consumer holds `frame_ready_i` high.

## Structure
- **Shared package `titan_bus_pkg`:**
  - `FRAME_BYTES` = 8.
  - Field widths: `INSTR_W` = 8, `ADDR_W` = 24, `VALUE_W` = 32.
  - Frame byte-offset constants.
  - Collector state enum (IDLE, COLLECT).
- **Sub-module `frame_timeout_counter`:** clear, enable, parameter `TIMEOUT_CYCLES`, one-cycle expiry pulse.
- Everything else stays in the top level, an estimated 150–250 lines.

## Test plan
- **Basic frame:** SS low; bytes 0x01, 0x00, 0x00, 0x02, 0xDE, 0xAD, 0xBE, 0xEF with `frame_ready_i` = 1 → one-cycle `frame_valid_o` with instruction 0x01, address 0x000002, value 0xDEADBEEF; `overflow_o` = 0.
- **Back-pressure:** `frame_ready_i` = 0; send 2 frames (A then B) → A is held stable and B is dropped with `overflow_o` = 1. Raise ready → A transfers. Pulse `overflow_clr_i` → `overflow_o` = 0.
- **Ready on the completion edge:** hold frame A; raise ready on the same edge that B's 8th byte arrives → B loads, valid stays 1, `overflow_o` = 0.
- **Timeout:** `TIMEOUT_CYCLES` = 16; send 3 bytes, then idle 16 cycles → `timeout_o` pulses once and index = 0. The next 8 bytes form a correct frame.
- **SS resync:** send 5 bytes, raise `spi_ss_i` for 1 cycle, then send a full frame → only the full frame appears; no timeout, no overflow.
- **Reset mid-operation:** assert `rst_n` = 0 mid-frame while a frame is held → all outputs 0. A subsequent full frame decodes correctly.
